// File: rtl/button_debouncer_if.sv
// Button debouncer signal bundle.
// Raw button in, debounced level and edge strobes out.
interface button_debouncer_if;
    logic button;     // raw pad input
    logic button_db;  // debounced level
    logic rise;       // one-cycle accepted 0->1 strobe
    logic fall;       // one-cycle accepted 1->0 strobe

    modport master (
        output button,
        input  button_db,
        input  rise,
        input  fall
    );

    modport slave (
        input  button,
        output button_db,
        output rise,
        output fall
    );
endinterface

// File: rtl/button_debouncer.sv
// Push-button debouncer: 4-state filter FSM, registered level + strobes.
// Ports: clk, reset (sync, active-high), bus (slave: button in;
// button_db, rise, fall out). Macro BUTTON_DEBOUNCER_SYNC_EN adds
// a 2-flop input synchronizer (+2 cycles latency).
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                clk,
    input  logic                reset,
    button_debouncer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE_LOW,
        FILTER_HIGH,
        IDLE_HIGH,
        FILTER_LOW
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_db;
    logic             r_rise;
    logic             r_fall;

`ifdef BUTTON_DEBOUNCER_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.button;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;
`else
    assign w_s = bus.button;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            r_db    <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            unique case (r_state)
                IDLE_LOW: begin
                    if (w_s) begin
                        r_state <= FILTER_HIGH;
                        r_cnt   <= CNT_W'(1);
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                FILTER_HIGH: begin
                    // any sample back at the old level restarts the filter
                    if (!w_s) begin
                        r_state <= IDLE_LOW;
                        r_cnt   <= '0;
                    end else if (r_cnt == LAST) begin
                        r_state <= IDLE_HIGH;
                        r_cnt   <= '0;
                        r_db    <= 1'b1;
                        r_rise  <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                IDLE_HIGH: begin
                    if (!w_s) begin
                        r_state <= FILTER_LOW;
                        r_cnt   <= CNT_W'(1);
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                FILTER_LOW: begin
                    if (w_s) begin
                        r_state <= IDLE_HIGH;
                        r_cnt   <= '0;
                    end else if (r_cnt == LAST) begin
                        r_state <= IDLE_LOW;
                        r_cnt   <= '0;
                        r_db    <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE_LOW;
                    r_cnt   <= '0;
                    r_db    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.button_db = r_db;
    assign bus.rise      = r_rise;
    assign bus.fall      = r_fall;

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer (DEBOUNCE_CYCLES = 8).
// Latency expectation follows BUTTON_DEBOUNCER_SYNC_EN.
module tb_button_debouncer;

    localparam int DC = 8;
`ifdef BUTTON_DEBOUNCER_SYNC_EN
    localparam int LAT = DC + 1;
`else
    localparam int LAT = DC - 1;
`endif

    typedef struct packed {
        logic btn;
        logic rst;
        logic db;
        logic rise;
        logic fall;
    } vec_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    int   cyc;
    vec_t vecs [64];
    int   nvec;

    button_debouncer_if bus ();

    button_debouncer #(
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act,
                         input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %b expected %b",
                     name, cyc, act, exp);
        end
    endtask

    // advance one edge and sample 1ns later; strobes never overlap
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        check("rise_fall_excl", bus.rise & bus.fall, 1'b0);
    endtask

    task automatic add(input logic b, input logic r, input logic d,
                       input logic ri, input logic f);
        vecs[nvec] = '{btn: b, rst: r, db: d, rise: ri, fall: f};
        nvec++;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        nvec  = 0;
        reset = 1'b1;
        bus.button = 1'b0;

        // reset, idle, accepted press, accepted release
        for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) add(0, 0, 0, 0, 0);
        for (int j = 0; j < LAT + 3; j++)
            add(1, 0, j >= LAT, j == LAT, 0);
        for (int j = 0; j < LAT + 3; j++)
            add(0, 0, j < LAT, 0, j == LAT);

        @(negedge clk);
        for (int i = 0; i < nvec; i++) begin
            bus.button = vecs[i].btn;
            reset      = vecs[i].rst;
            tick();
            check("tbl_db",   bus.button_db, vecs[i].db);
            check("tbl_rise", bus.rise,      vecs[i].rise);
            check("tbl_fall", bus.fall,      vecs[i].fall);
        end

        // bouncing every 3 cycles never gets accepted
        for (int i = 0; i < 40; i++) begin
            bus.button = ((i / 3) % 2) == 0;
            tick();
            check("bounce_db",   bus.button_db, 1'b0);
            check("bounce_rise", bus.rise,      1'b0);
        end
        bus.button = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bounce_idle_db", bus.button_db, 1'b0);
            check("bounce_idle_f",  bus.fall,      1'b0);
        end

        // get to button_db = 1
        bus.button = 1'b1;
        for (int j = 0; j < LAT + 2; j++) tick();
        check("press_db", bus.button_db, 1'b1);

        // 7-cycle drop is one short of acceptance
        bus.button = 1'b0;
        for (int j = 0; j < 7; j++) begin
            tick();
            check("short_drop_fall", bus.fall, 1'b0);
        end
        bus.button = 1'b1;
        for (int j = 0; j < 20; j++) begin
            tick();
            check("short_drop_db",   bus.button_db, 1'b1);
            check("short_drop_fall", bus.fall,      1'b0);
        end

        // final drop: fall after the full latency
        bus.button = 1'b0;
        for (int j = 0; j < LAT + 3; j++) begin
            tick();
            check("drop_fall", bus.fall,      j == LAT);
            check("drop_db",   bus.button_db, j < LAT);
        end

        // reset in the middle of FILTER_HIGH
        bus.button = 1'b1;
        for (int j = 0; j < 5; j++) tick();
        check("pre_rst_db", bus.button_db, 1'b0);
        reset = 1'b1;
        for (int j = 0; j < 2; j++) begin
            tick();
            check("rst_db",   bus.button_db, 1'b0);
            check("rst_rise", bus.rise,      1'b0);
        end
        reset = 1'b0;
        for (int j = 0; j < LAT + 3; j++) begin
            tick();
            check("post_rst_rise", bus.rise,      j == LAT);
            check("post_rst_db",   bus.button_db, j >= LAT);
        end

        // reset while high clears the level without a fall strobe
        reset = 1'b1;
        tick();
        check("rst_high_db",   bus.button_db, 1'b0);
        check("rst_high_fall", bus.fall,      1'b0);
        reset = 1'b0;
        bus.button = 1'b0;
        for (int j = 0; j < 15; j++) begin
            tick();
            check("rst_high_idle", bus.fall | bus.rise, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
